spi_xfer_ctrl: RTL and testbench
================================

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter SPI_TRF_BIT, default 8: width of one SPI word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two: depth of the command FIFO and of the response FIFO.
REQ-003 SHALL have parameter TIMEOUT, default 4096: maximum number of cycles allowed for one transfer.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: cmd_valid in 1, cmd_ready out 1, cmd_mode in 2 (1=TX, 2=RX, 3=full duplex), cmd_data in SPI_TRF_BIT; valid/ready command push.
REQ-007 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_data out SPI_TRF_BIT; valid/ready received-word pop.
REQ-008 SHALL have ports: req out 2, wait_duration out 8, din_master out SPI_TRF_BIT; drive spi_top.
REQ-009 SHALL have ports: dout_master in SPI_TRF_BIT, done_tx in 1, done_rx in 1; returned from spi_top.
REQ-010 SHALL have ports: cfg_wait in 8 (forwarded to wait_duration), cfg_gap in 4 (idle cycles between transfers), busy out 1, err_timeout out 1 (single-cycle pulse).

Function
REQ-011 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready = command FIFO not full; cmd_mode 0 SHALL be accepted and discarded without a transfer.
REQ-012 SHALL run FSM states IDLE, ISSUE, XFER, STORE, GAP.
REQ-013 IDLE -> ISSUE when command FIFO non-empty; the entry is popped on that edge and registered as cur_mode/cur_data.
REQ-014 ISSUE (1 cycle): drive req=cur_mode, din_master=cur_data, wait_duration=cfg_wait; clear done flags and timeout counter; go to XFER.
REQ-015 XFER: hold req, din_master and wait_duration stable; set sticky flags tx_seen on done_tx and rx_seen on done_rx.
REQ-016 XFER exits when the required flag set is complete: mode 1 needs tx_seen, mode 2 needs rx_seen, mode 3 needs both, in any order or in the same cycle; done pulses present in the ISSUE cycle SHALL be ignored.
REQ-017 On XFER exit, req SHALL be 0 in the next cycle; for modes 2 and 3 dout_master, sampled in the completing cycle, goes to STORE; for mode 1 go directly to GAP.
REQ-018 STORE pushes the word into the response FIFO; if full, SHALL stall in STORE with busy=1 until space; no word is ever dropped.
REQ-019 GAP holds req=0 for max(cfg_gap,1) cycles, then returns to IDLE.
REQ-020 If the timeout counter reaches TIMEOUT in XFER: pulse err_timeout, drop req to 0, push nothing, go to GAP.
REQ-021 rsp_valid = response FIFO non-empty; rsp_data is the FIFO head; pop on rsp_valid && rsp_ready; simultaneous push and pop on a full FIFO SHALL succeed.
REQ-022 busy = 1 in every state except IDLE, or whenever the command FIFO is non-empty.
REQ-023 Command ordering SHALL be strict FIFO; the response order SHALL equal the command order of mode-2/3 commands.

Reset
REQ-024 With rst=0 at a clock edge: FSM to IDLE, both FIFOs emptied, counters and flags cleared.
REQ-025 During reset and on the first cycle after it: req=0, din_master=0, wait_duration=0, cmd_ready=0 while rst=0, rsp_valid=0, busy=0, err_timeout=0.
REQ-026 Reset asserted mid-transfer SHALL abort it immediately, producing no response and no err_timeout pulse.

Structure
REQ-027 Package spi_pkg SHALL hold the req mode enum (IDLE=0, TX=1, RX=2, FD=3) and the FSM state enum.
REQ-028 Both FIFOs SHALL be instances of one sub-module spi_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, count).

Verification
REQ-029 Push TX 0xA5 with cfg_gap=2 -> req=1 and din_master=0xA5 from ISSUE until done_tx; then req=0 for 2 cycles; no rsp_valid.
REQ-030 Push RX and FD with slave data 0x3C and 0xC3 -> rsp_data 0x3C then 0xC3 in order; the FD command completes only after both done_tx and done_rx.
REQ-031 Push 4 commands back-to-back with FIFO_DEPTH=4 -> cmd_ready=0 on the 5th attempt; all 4 transfers execute in order.
REQ-032 Hold rsp_ready=0 through 5 RX commands -> 4 responses buffered, FSM stalls in STORE, busy=1; one pop releases the 5th push.
REQ-033 Suppress done_tx with TIMEOUT=64 -> err_timeout pulses exactly once at cycle 64 of XFER, req=0, next command proceeds.
REQ-034 Assert rst=0 during XFER of an RX command -> req=0 next cycle, FIFOs empty, no response, no err_timeout.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI transfer controller: request modes and controller states.
package spi_pkg;

  typedef enum logic [1:0] {
    REQ_IDLE = 2'd0,
    REQ_TX   = 2'd1,
    REQ_RX   = 2'd2,
    REQ_FD   = 2'd3
  } req_mode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    XFER  = 3'd2,
    STORE = 3'd3,
    GAP   = 3'd4
  } xfer_state_t;

  function automatic logic mode_has_rx(input req_mode_t m);
    return (m == REQ_RX) || (m == REQ_FD);
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO, power-of-two depth; a push into a full FIFO succeeds when a pop happens in the same cycle.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Queues SPI commands, sequences one spi_top transfer at a time and buffers received words in order.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int SPI_TRF_BIT = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_mode,
  input  logic [SPI_TRF_BIT-1:0] cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [SPI_TRF_BIT-1:0] rsp_data,
  output logic [1:0]             req,
  output logic [7:0]             wait_duration,
  output logic [SPI_TRF_BIT-1:0] din_master,
  input  logic [SPI_TRF_BIT-1:0] dout_master,
  input  logic                   done_tx,
  input  logic                   done_rx,
  input  logic [7:0]             cfg_wait,
  input  logic [3:0]             cfg_gap,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] RSP_FULL_CNT = CW'(FIFO_DEPTH);

  xfer_state_t            state;
  req_mode_t              cur_mode;
  logic [SPI_TRF_BIT-1:0] cur_data;
  logic [SPI_TRF_BIT-1:0] rsp_word;
  logic [7:0]             cur_wait;
  logic                   tx_seen;
  logic                   rx_seen;
  logic [TW-1:0]          timer;
  logic [3:0]             gap_cnt;
  logic [3:0]             gap_last;

  logic                     cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CW-1:0]            cmd_count;
  logic [SPI_TRF_BIT+1:0]   cmd_head;
  logic                     rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [CW-1:0]            rsp_count;

  logic tx_now, rx_now, xfer_done, timed_out, store_ok, drive;

  // Mode-0 commands complete the handshake but never enter the queue.
  assign cmd_ready = rst && !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready && (cmd_mode != 2'd0);
  assign cmd_pop   = (state == IDLE) && !cmd_empty;

  spi_sync_fifo #(.WIDTH(SPI_TRF_BIT + 2), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .din   ({cmd_mode, cmd_data}),
    .pop   (cmd_pop),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  assign rsp_valid = rst && !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_push  = (state == STORE);
  assign store_ok  = !rsp_full || rsp_pop;

  spi_sync_fifo #(.WIDTH(SPI_TRF_BIT), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .din   (rsp_word),
    .pop   (rsp_pop),
    .dout  (rsp_data),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  // Done pulses are folded in the same cycle so simultaneous tx/rx completion exits at once.
  assign tx_now = tx_seen | done_tx;
  assign rx_now = rx_seen | done_rx;

  always_comb begin
    xfer_done = 1'b1;
    case (cur_mode)
      REQ_TX:  xfer_done = tx_now;
      REQ_RX:  xfer_done = rx_now;
      REQ_FD:  xfer_done = tx_now && rx_now;
      default: xfer_done = 1'b1;
    endcase
  end

  assign timed_out = (state == XFER) && !xfer_done && (timer == TMO_LAST);
  assign gap_last  = (cfg_gap == 4'd0) ? 4'd0 : cfg_gap - 4'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cur_mode <= REQ_IDLE;
      cur_data <= '0;
      cur_wait <= '0;
      rsp_word <= '0;
      tx_seen  <= 1'b0;
      rx_seen  <= 1'b0;
      timer    <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!cmd_empty) begin
            cur_mode <= req_mode_t'(cmd_head[SPI_TRF_BIT +: 2]);
            cur_data <= cmd_head[SPI_TRF_BIT-1:0];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cur_wait <= cfg_wait;
          tx_seen  <= 1'b0;
          rx_seen  <= 1'b0;
          timer    <= '0;
          state    <= XFER;
        end
        XFER: begin
          tx_seen <= tx_now;
          rx_seen <= rx_now;
          timer   <= timer + 1'b1;
          if (xfer_done) begin
            gap_cnt <= '0;
            if (mode_has_rx(cur_mode)) begin
              rsp_word <= dout_master;
              state    <= STORE;
            end else begin
              state <= GAP;
            end
          end else if (timed_out) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        STORE: begin
          if (store_ok) state <= GAP;
        end
        GAP: begin
          if (gap_cnt == gap_last) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by rst so an aborted transfer releases spi_top in the reset cycle itself.
  assign drive         = rst && ((state == ISSUE) || (state == XFER));
  assign req           = drive ? cur_mode : REQ_IDLE;
  assign din_master    = drive ? cur_data : '0;
  assign wait_duration = !rst ? 8'd0 :
                         (state == ISSUE) ? cfg_wait :
                         (state == XFER)  ? cur_wait : 8'd0;
  assign busy          = rst && ((state != IDLE) || (cmd_count != '0));
  assign err_timeout   = rst && timed_out;

  a_rsp_full_count: assert property (@(posedge clk) disable iff (!rst)
    rsp_full == (rsp_count == RSP_FULL_CNT));

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl with a behavioural spi_top slave model.
module tb_spi_xfer_ctrl;

  localparam int W   = 8;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_mode;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [1:0]   req;
  logic [7:0]   wait_duration;
  logic [W-1:0] din_master;
  logic [W-1:0] dout_master;
  logic         done_tx;
  logic         done_rx;
  logic [7:0]   cfg_wait;
  logic [3:0]   cfg_gap;
  logic         busy;
  logic         err_timeout;

  spi_xfer_ctrl #(.SPI_TRF_BIT(W), .FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mode      (cmd_mode),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .req           (req),
    .wait_duration (wait_duration),
    .din_master    (din_master),
    .dout_master   (dout_master),
    .done_tx       (done_tx),
    .done_rx       (done_rx),
    .cfg_wait      (cfg_wait),
    .cfg_gap       (cfg_gap),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] data;
    logic [7:0]   wt;
    int           len;     // ISSUE + XFER cycles with req high; 0 = not checked
    int           err_at;  // req-high cycle index of err_timeout; 0 = none
  } xfer_t;

  typedef struct {
    int           tx_dly;  // 0 = never signal done_tx
    int           rx_dly;
    logic [W-1:0] sdata;
  } slave_t;

  xfer_t        exp_xq[$];
  slave_t       slave_q[$];
  logic [W-1:0] exp_rq[$];

  int n_cmp   = 0;
  int n_bad   = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] mode, input logic [W-1:0] data, input int tx_dly,
                       input int rx_dly, input logic [W-1:0] sdata, input int len,
                       input int err_at, input bit want_rsp);
    bit rdy;
    bit accepted;
    accepted = 1'b0;
    if (mode != 2'd0) begin
      slave_q.push_back('{tx_dly, rx_dly, sdata});
      exp_xq.push_back('{mode, data, cfg_wait, len, err_at});
      if (want_rsp) exp_rq.push_back(sdata);
    end
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_data  = data;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", accepted, 1'b1);
  endtask

  task automatic wait_idle();
    int quiet;
    int k;
    quiet = 0;
    k = 0;
    while (quiet < 2 && k < 1000) begin
      @(negedge clk);
      k++;
      if (!busy && !rsp_valid) quiet++;
      else quiet = 0;
    end
    check("idle_reached", (quiet >= 2), 1'b1);
    cyc(1);
  endtask

  // Slave model: starts on each rising req, pulses done_tx/done_rx after the configured cycles.
  bit     s_act;
  int     s_cnt;
  slave_t s_cur;
  initial begin
    done_tx     = 1'b0;
    done_rx     = 1'b0;
    dout_master = '0;
    s_act       = 1'b0;
    s_cnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      done_tx = 1'b0;
      done_rx = 1'b0;
      if (req == 2'd0) begin
        s_act = 1'b0;
      end else if (!s_act) begin
        s_act = 1'b1;
        s_cnt = 0;
        if (slave_q.size() != 0) s_cur = slave_q.pop_front();
        else s_cur = '{0, 0, '0};
        dout_master = s_cur.sdata;
      end else begin
        s_cnt++;
        if (req[0] && s_cur.tx_dly != 0 && s_cnt == s_cur.tx_dly) done_tx = 1'b1;
        if (req[1] && s_cur.rx_dly != 0 && s_cnt == s_cur.rx_dly) done_rx = 1'b1;
      end
    end
  end

  // Transfer monitor: records each req-high window and compares it with the expected transfer.
  bit    m_act = 1'b0;
  bit    m_unstable;
  xfer_t m_cur;
  xfer_t m_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (err_timeout === 1'b1) err_cnt++;
      if (req !== 2'd0 && req !== 2'bxx) begin
        if (!m_act) begin
          m_act      = 1'b1;
          m_unstable = 1'b0;
          m_cur      = '{req, din_master, wait_duration, 1, 0};
        end else begin
          m_cur.len++;
          if (req !== m_cur.mode || din_master !== m_cur.data || wait_duration !== m_cur.wt)
            m_unstable = 1'b1;
        end
        if (err_timeout === 1'b1 && m_cur.err_at == 0) m_cur.err_at = m_cur.len;
      end else if (m_act) begin
        m_act = 1'b0;
        if (exp_xq.size() == 0) begin
          check("xfer_unexpected", 1'b1, 1'b0);
        end else begin
          m_exp = exp_xq.pop_front();
          check("xfer_mode", m_cur.mode, m_exp.mode);
          check("xfer_din", m_cur.data, m_exp.data);
          check("xfer_wait", m_cur.wt, m_exp.wt);
          check("xfer_stable", m_unstable, 1'b0);
          if (m_exp.len != 0) check("xfer_len", m_cur.len, m_exp.len);
          check("xfer_err_at", m_cur.err_at, m_exp.err_at);
        end
      end
    end
  end

  // Response monitor: pops the expected word on every accepted response.
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_rq.size() == 0) check("rsp_unexpected", {24'd0, rsp_data}, 32'hFFFF_FFFF);
        else check("rsp_data", rsp_data, exp_rq.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int g;
  int k;
  int err0;

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    cfg_wait  = 8'h11;
    cfg_gap   = 4'd2;

    // Reset state
    cyc(3);
    @(negedge clk);
    check("rst_req", req, 2'd0);
    check("rst_din", din_master, 8'h00);
    check("rst_wait", wait_duration, 8'h00);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_req", req, 2'd0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_rsp_valid", rsp_valid, 1'b0);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);
    cyc(1);

    // Mode 0 is accepted but produces no transfer
    issue(2'd0, 8'hFF, 0, 0, 8'h00, 0, 0, 1'b0);
    cyc(3);
    check("mode0_busy", busy, 1'b0);

    // TX 0xA5, done_tx after 3 XFER cycles, gap of 2
    issue(2'd1, 8'hA5, 3, 0, 8'h00, 4, 0, 1'b0);
    g = 0;
    k = 0;
    while (req == 2'd0 && k < 100) begin @(negedge clk); k++; end
    while (req != 2'd0 && k < 200) begin @(negedge clk); k++; end
    while (busy && req == 2'd0 && k < 300) begin g++; @(negedge clk); k++; end
    check("gap_bounded", (k < 300), 1'b1);
    check("gap_len", g, 2);
    check("tx_no_rsp", rsp_valid, 1'b0);
    wait_idle();

    // RX then FD, responses in order; FD waits for the later done_rx
    cfg_gap  = 4'd0;
    cfg_wait = 8'h22;
    issue(2'd2, 8'h00, 0, 2, 8'h3C, 3, 0, 1'b1);
    issue(2'd3, 8'h5F, 2, 5, 8'hC3, 6, 0, 1'b1);
    wait_idle();
    check("rxfd_rsp_drained", exp_rq.size(), 0);

    // Fill the command FIFO behind a long transfer
    cfg_gap = 4'd1;
    issue(2'd1, 8'h10, 20, 0, 8'h00, 21, 0, 1'b0);
    cyc(3);
    for (int i = 0; i < 4; i++) issue(2'd1, 8'h20 + 8'(i), 2, 0, 8'h00, 3, 0, 1'b0);
    cmd_valid = 1'b1;
    cmd_mode  = 2'd1;
    cmd_data  = 8'hEE;
    @(negedge clk);
    check("cmd_ready_full", cmd_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle();

    // Response back-pressure: 4 buffered, 5th stalls in STORE until one pop
    cfg_gap   = 4'd0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) issue(2'd2, 8'h40 + 8'(i), 0, 1, 8'h51 + 8'(i), 2, 0, 1'b1);
    cyc(40);
    @(negedge clk);
    check("stall_busy", busy, 1'b1);
    check("stall_req", req, 2'd0);
    check("stall_rsp_valid", rsp_valid, 1'b1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    cyc(1);
    rsp_ready = 1'b0;
    cyc(4);
    @(negedge clk);
    check("release_busy", busy, 1'b0);
    check("release_rsp_valid", rsp_valid, 1'b1);
    cyc(1);
    rsp_ready = 1'b1;
    wait_idle();

    // Timeout on a TX with no done_tx, then a normal RX proceeds
    cfg_gap = 4'd1;
    err0 = err_cnt;
    issue(2'd1, 8'h66, 0, 0, 8'h00, TMO + 1, TMO + 1, 1'b0);
    issue(2'd2, 8'h77, 0, 2, 8'h5A, 3, 0, 1'b1);
    wait_idle();
    check("timeout_pulses", err_cnt - err0, 1);

    // Reset during an RX transfer aborts it silently
    issue(2'd2, 8'h88, 0, 30, 8'h99, 0, 0, 1'b0);
    k = 0;
    while (req == 2'd0 && k < 100) begin @(negedge clk); k++; end
    check("abort_started", (req == 2'd2), 1'b1);
    cyc(5);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_req", req, 2'd0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_cmd_ready", cmd_ready, 1'b0);
    check("abort_err", err_timeout, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(40);
    @(negedge clk);
    check("abort_no_rsp", rsp_valid, 1'b0);
    cyc(1);

    // Recovery after reset
    issue(2'd3, 8'hAB, 3, 3, 8'hE7, 4, 0, 1'b1);
    wait_idle();

    check("xfer_queue_empty", exp_xq.size(), 0);
    check("rsp_queue_empty", exp_rq.size(), 0);
    check("err_total", err_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
